booth_seq_mult: RTL and testbench

Iterative 12×12 signed radix-4 Booth multiplier with a start/done handshake, used by the FFT butterfly datapath for twiddle products. It is the encoder and sequencer side of the Booth scheme. It latches both operands, recodes the multiplier into six overlapping 3-bit windows, and accumulates one signed Booth digit times the multiplicand per cycle into a 24-bit product. The result is presented with a one-cycle `done` pulse.

---
 rtl/booth_pkg.sv | 25 ++
 rtl/booth_r4_addend.sv | 29 ++
 rtl/booth_seq_mult.sv | 94 +++++++++
 tb/tb_booth_seq_mult.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared widths, FSM encoding and radix-4 Booth window codes for the
// sequential Booth multiplier.
package booth_pkg;

    localparam int W_IN     = 12;
    localparam int W_OUT    = 2 * W_IN;
    localparam int N_DIGITS = W_IN / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Window = {b[2i+1], b[2i], b[2i-1]}; names give the selected digit.
    localparam logic [2:0] WIN_ZERO_LO = 3'b000;
    localparam logic [2:0] WIN_P1_A    = 3'b001;
    localparam logic [2:0] WIN_P1_B    = 3'b010;
    localparam logic [2:0] WIN_P2      = 3'b011;
    localparam logic [2:0] WIN_M2      = 3'b100;
    localparam logic [2:0] WIN_M1_A    = 3'b101;
    localparam logic [2:0] WIN_M1_B    = 3'b110;
    localparam logic [2:0] WIN_ZERO_HI = 3'b111;

endpackage

// File: rtl/booth_r4_addend.sv
// Radix-4 Booth digit selector: maps one 3-bit window onto the signed
// multiple of the (already weighted) multiplicand to be accumulated.
module booth_r4_addend #(
    parameter int W_OUT = booth_pkg::W_OUT
) (
    input  logic [2:0]       window,
    input  logic [W_OUT-1:0] mcand,
    output logic [W_OUT-1:0] addend
);
    import booth_pkg::*;

    logic [W_OUT-1:0] mcand_x2;

    assign mcand_x2 = mcand << 1;

    always_comb begin
        // NOTE: default assignment first so every path drives addend; no latch is inferred.
        addend = '0;
        case (window)
            WIN_ZERO_LO, WIN_ZERO_HI: addend = '0;
            WIN_P1_A, WIN_P1_B:       addend = mcand;
            WIN_P2:                   addend = mcand_x2;
            WIN_M2:                   addend = ~mcand_x2 + W_OUT'(1);
            WIN_M1_A, WIN_M1_B:       addend = ~mcand + W_OUT'(1);
            default:                  addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative signed radix-4 Booth multiplier: one Booth digit per cycle,
// start/ready handshake in, one-cycle done pulse out with a held product.
module booth_seq_mult #(
    parameter int W_IN  = booth_pkg::W_IN,
    parameter int W_OUT = 2 * W_IN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W_IN-1:0]  mult_a,
    input  logic [W_IN-1:0]  mult_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [W_OUT-1:0] product
);
    import booth_pkg::*;

    localparam int              N_DIG    = W_IN / 2;
    localparam int              CNT_W    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIG - 1);

    state_t             state_q, state_d;
    logic [W_OUT-1:0]   mcand_q;
    logic [W_OUT-1:0]   acc_q;
    logic [W_OUT-1:0]   addend;
    logic [W_OUT-1:0]   acc_sum;
    logic [W_IN:0]      recode_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               last;

    assign accept  = ready && start;
    assign last    = (state_q == RUN) && (cnt_q == LAST_CNT);
    assign acc_sum = acc_q + addend;

    booth_r4_addend #(.W_OUT(W_OUT)) u_addend (
        .window (recode_q[2:0]),
        .mcand  (mcand_q),
        .addend (addend)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == RUN);
        ready = !busy;
    end

    // Multiplicand moves up two places per digit so each addend lands at its weight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            recode_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            mcand_q  <= {{(W_OUT - W_IN){mult_a[W_IN-1]}}, mult_a};
            recode_q <= {mult_b, 1'b0};
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            mcand_q  <= mcand_q << 2;
            recode_q <= {{2{recode_q[W_IN]}}, recode_q[W_IN:2]};
            acc_q    <= acc_sum;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= last;
            if (last) product <= acc_sum;
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: transaction-level model compared
// every cycle, plus directed operations with literal expected products.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [11:0] mult_a = '0;
    logic [11:0] mult_b = '0;
    logic        ready, busy, done;
    logic [23:0] product;

    int checks = 0;
    int errors = 0;

    booth_seq_mult dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mult_a  (mult_a),
        .mult_b  (mult_b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start yields done exactly 6 edges later with a*b truncated to 24 bits.
    int          edge_k = 0;
    int          done_at = 0;
    logic        busy_m = 1'b0;
    logic        done_m = 1'b0;
    logic [23:0] pending = '0;
    logic [23:0] prod_m = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_k <= 0;
            busy_m <= 1'b0;
            done_m <= 1'b0;
            prod_m <= '0;
        end else begin
            edge_k <= edge_k + 1;
            done_m <= 1'b0;
            if (busy_m && (edge_k + 1 == done_at)) begin
                done_m <= 1'b1;
                prod_m <= pending;
                busy_m <= 1'b0;
            end else if (!busy_m && start) begin
                busy_m  <= 1'b1;
                done_at <= edge_k + 1 + 6;
                pending <= 24'(int'($signed(mult_a)) * int'($signed(mult_b)));
            end
        end
    end

    always @(negedge clk) begin
        check("ready", 32'(ready), 32'(!busy_m));
        check("busy", 32'(busy), 32'(busy_m));
        check("done", 32'(done), 32'(done_m));
        check("product", 32'(product), 32'(prod_m));
    end

    // Optional disturb pulses start with other operands while the run is in progress.
    task automatic run_op(input string name, input logic [11:0] a, input logic [11:0] b,
                          input logic [23:0] exp, input bit disturb);
        int lat;
        @(negedge clk);
        start  = 1'b1;
        mult_a = a;
        mult_b = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (disturb && i == 1) begin
                start  = 1'b1;
                mult_a = 12'd7;
                mult_b = 12'd9;
            end
            if (disturb && i == 2) start = 1'b0;
        end
        start = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'd6);
        check({name, "_product"}, 32'(product), 32'(exp));
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        start  = 1'b1;
        mult_a = 12'd3;
        mult_b = 12'd5;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_product", 32'(product), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(ready), 32'h1);
        repeat (3) @(negedge clk);
        check("rst_hold_done", 32'(done), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 check("rst_no_done", 32'(done), 32'h0);
        end
    endtask

    task automatic back_to_back();
        int lat1, lat2;
        @(negedge clk);
        start  = 1'b1;
        mult_a = 12'd3;
        mult_b = 12'd5;
        @(posedge clk);
        #1;
        mult_a = -12'sd7;
        mult_b = 12'd11;
        lat1 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat1 = i;
                break;
            end
        end
        check("b2b_first_latency", 32'(lat1), 32'd6);
        check("b2b_first_product", 32'(product), 32'h00000F);
        lat2 = 0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk);
            #1;
            if (j == 1) start = 1'b0;
            if (done) begin
                lat2 = j;
                break;
            end
        end
        check("b2b_second_spacing", 32'(lat2), 32'd7);
        check("b2b_second_product", 32'(product), 32'hFFFFB3);
    endtask

    function automatic logic [11:0] rnd_op();
        logic [11:0] corners [4];
        corners[0] = 12'h800;
        corners[1] = 12'h7FF;
        corners[2] = 12'h000;
        corners[3] = 12'hFFF;
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 3)];
        return 12'($urandom);
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready), 32'h1);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_product", 32'(product), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        run_op("basic_3x5", 12'd3, 12'd5, 24'h00000F, 1'b0);
        reset_mid_run();
        run_op("after_rst_3x5", 12'd3, 12'd5, 24'h00000F, 1'b0);
        run_op("min_x_min", 12'h800, 12'h800, 24'h400000, 1'b0);
        run_op("min_x_max", 12'h800, 12'h7FF, 24'hC00800, 1'b0);
        run_op("max_x_max", 12'h7FF, 12'h7FF, 24'h3FF001, 1'b0);
        run_op("m1_x_1", 12'hFFF, 12'd1, 24'hFFFFFF, 1'b0);
        run_op("zero_x_neg", 12'd0, -12'sd1234, 24'h000000, 1'b0);
        run_op("pos_x_zero", 12'd1234, 12'd0, 24'h000000, 1'b0);
        run_op("start_in_run", 12'd3, 12'd5, 24'h00000F, 1'b1);
        back_to_back();

        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) != 0);
            mult_a = rnd_op();
            mult_b = rnd_op();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
